mem_port_arbiter: RTL and testbench

Sequential arbiter sharing one single-port instruction/data memory between the fetch stage and the load/store (MEM) stage of the core. The MEM stage issues its requests from the decoder's MemRead/MemWrite controls. Each accepted request is sequenced through a fixed-latency memory access, and the read data or write acknowledge is returned to the winning requester. Data requests have priority, with bounded anti-starvation for fetch.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_pick.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int XLEN   = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  // Saturating 3-bit increment used by the starvation counter.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v, input logic [2:0] max_v);
    logic [2:0] r;
    if (v >= max_v) begin
      r = max_v;
    end else begin
      r = v + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requesters, with a saturating
// counter that bounds how long a pending fetch can be passed over.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_window,   // arbiter is at an accept point (IDLE or RESP)
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_if_grant,
  output logic o_d_grant
);

  localparam logic [2:0] CNT_MAX = 3'(STARVE_MAX);

  logic [2:0] r_starve_cnt;
  logic       w_force_if;

  // Data wins by default; fetch wins once it has been passed over STARVE_MAX times.
  always_comb begin
    o_if_grant = 1'b0;
    o_d_grant  = 1'b0;
    w_force_if = i_if_req && (r_starve_cnt == CNT_MAX);
    if (!i_window) begin
      o_if_grant = 1'b0;
      o_d_grant  = 1'b0;
    end else if (i_d_req && !w_force_if) begin
      o_d_grant = 1'b1;
    end else if (i_if_req) begin
      o_if_grant = 1'b1;
    end else begin
      o_if_grant = 1'b0;
      o_d_grant  = 1'b0;
    end
  end

  // Count data grants that bypass a waiting fetch; cleared when fetch is served or idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= 3'd0;
    end else if (i_window) begin
      if (!i_if_req || o_if_grant) begin
        r_starve_cnt <= 3'd0;
      end else if (o_d_grant) begin
        r_starve_cnt <= sat_inc3(r_starve_cnt, CNT_MAX);
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// Each accepted request runs ISSUE -> WAIT (LATENCY-1 cycles) -> RESP; a new
// request may be accepted in RESP so accesses run back to back.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [XLEN-1:0]   i_if_addr,
  output logic              o_if_ready,
  output logic              o_if_valid,
  output logic [XLEN-1:0]   o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_wen,
  input  logic [XLEN-1:0]   i_d_addr,
  input  logic [XLEN-1:0]   i_d_wdata,
  input  logic [MASK_W-1:0] i_d_mask,
  output logic              o_d_ready,
  output logic              o_d_valid,
  output logic [XLEN-1:0]   o_d_rdata,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [MASK_W-1:0] o_mem_mask,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_busy
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [3:0]        r_wait_cnt;
  arb_owner_e        r_owner;
  logic              r_wen;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [MASK_W-1:0] r_mem_mask;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic              r_if_valid;
  logic              r_d_valid;
  logic [XLEN-1:0]   r_if_rdata;
  logic [XLEN-1:0]   r_d_rdata;

  logic              w_window;
  logic              w_last;
  logic              w_if_grant;
  logic              w_d_grant;
  logic              w_accept;
  logic              w_acc_wen;
  logic [XLEN-1:0]   w_acc_addr;
  logic [XLEN-1:0]   w_acc_wdata;
  logic [MASK_W-1:0] w_acc_mask;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_window   (w_window),
    .i_if_req   (i_if_req),
    .i_d_req    (i_d_req),
    .o_if_grant (w_if_grant),
    .o_d_grant  (w_d_grant)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: accept from IDLE/RESP, fixed-length access otherwise.
  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE:    w_next_state = w_accept ? ISSUE : IDLE;
      ISSUE:   w_next_state = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    w_next_state = (r_wait_cnt == 4'd1) ? RESP : WAIT;
      RESP:    w_next_state = w_accept ? ISSUE : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State decode: accept window, busy flag and last cycle of the memory access.
  always_comb begin
    w_window = 1'b0;
    o_busy   = 1'b1;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        w_window = 1'b1;
        o_busy   = 1'b0;
      end
      ISSUE:   w_last = (LATENCY == 1);
      WAIT:    w_last = (r_wait_cnt == 4'd1);
      RESP:    w_window = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

  // Mux the winning requester's fields for latching on accept.
  always_comb begin
    w_accept = w_if_grant | w_d_grant;
    if (w_d_grant) begin
      w_acc_wen   = i_d_wen;
      w_acc_addr  = i_d_addr;
      w_acc_wdata = i_d_wdata;
      w_acc_mask  = i_d_mask;
    end else begin
      w_acc_wen   = 1'b0;
      w_acc_addr  = i_if_addr;
      w_acc_wdata = {XLEN{1'b0}};
      w_acc_mask  = {MASK_W{1'b1}};
    end
  end

  // WAIT counter: loaded on the way into WAIT, counts down to 1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state == ISSUE) begin
      r_wait_cnt <= LAT_M1;
    end else if (r_state == WAIT) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Request latch and one-cycle memory strobes issued the cycle after accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner     <= OWN_IF;
      r_wen       <= 1'b0;
      r_mem_addr  <= {XLEN{1'b0}};
      r_mem_wdata <= {XLEN{1'b0}};
      r_mem_mask  <= {MASK_W{1'b0}};
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
    end else begin
      r_mem_ren <= w_accept & ~w_acc_wen;
      r_mem_wen <= w_accept & w_acc_wen;
      if (w_accept) begin
        r_owner     <= w_d_grant ? OWN_D : OWN_IF;
        r_wen       <= w_acc_wen;
        r_mem_addr  <= w_acc_addr;
        r_mem_wdata <= w_acc_wdata;
        r_mem_mask  <= w_acc_mask;
      end else begin
        r_owner     <= r_owner;
        r_wen       <= r_wen;
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
        r_mem_mask  <= r_mem_mask;
      end
    end
  end

  // Response capture at the end of the access; valid pulses in RESP for the owner only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_rdata <= {XLEN{1'b0}};
      r_d_rdata  <= {XLEN{1'b0}};
    end else begin
      r_if_valid <= w_last && (r_owner == OWN_IF);
      r_d_valid  <= w_last && (r_owner == OWN_D);
      if (w_last && (r_owner == OWN_IF)) begin
        r_if_rdata <= i_mem_rdata;
      end else begin
        r_if_rdata <= r_if_rdata;
      end
      if (w_last && (r_owner == OWN_D)) begin
        r_d_rdata <= r_wen ? {XLEN{1'b0}} : i_mem_rdata;
      end else begin
        r_d_rdata <= r_d_rdata;
      end
    end
  end

  assign o_if_ready  = w_if_grant;
  assign o_d_ready   = w_d_grant;
  assign o_if_valid  = r_if_valid;
  assign o_d_valid   = r_d_valid;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_mask  = r_mem_mask;
  assign o_mem_ren   = r_mem_ren;
  assign o_mem_wen   = r_mem_wen;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances (LATENCY 2, 1, 4) share stimulus;
// each scenario checks only the instance it targets.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        d_req = 1'b0;
  logic        d_wen = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [3:0]  d_mask = 4'd0;
  logic [31:0] mem_rdata = 32'd0;

  logic [2:0]  if_ready, if_valid, d_ready, d_valid, mem_ren, mem_wen, busy;
  logic [31:0] if_rdata  [3];
  logic [31:0] d_rdata   [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [3:0]  mem_mask  [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
      .STARVE_MAX (2)
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_if_req    (if_req),
      .i_if_addr   (if_addr),
      .o_if_ready  (if_ready[g]),
      .o_if_valid  (if_valid[g]),
      .o_if_rdata  (if_rdata[g]),
      .i_d_req     (d_req),
      .i_d_wen     (d_wen),
      .i_d_addr    (d_addr),
      .i_d_wdata   (d_wdata),
      .i_d_mask    (d_mask),
      .o_d_ready   (d_ready[g]),
      .o_d_valid   (d_valid[g]),
      .o_d_rdata   (d_rdata[g]),
      .o_mem_addr  (mem_addr[g]),
      .o_mem_wdata (mem_wdata[g]),
      .o_mem_mask  (mem_mask[g]),
      .o_mem_ren   (mem_ren[g]),
      .o_mem_wen   (mem_wen[g]),
      .i_mem_rdata (mem_rdata),
      .o_busy      (busy[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = 32'd0;
    d_req   = 1'b0;
    d_wen   = 1'b0;
    d_addr  = 32'd0;
    d_wdata = 32'd0;
    d_mask  = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // ---- 1: lone fetch, LATENCY = 2 (instance 0) ----
    do_reset();
    check_eq("rst_busy",     32'(busy[0]),    32'd0);
    check_eq("rst_ren",      32'(mem_ren[0]), 32'd0);
    check_eq("rst_if_valid", 32'(if_valid[0]), 32'd0);
    check_eq("rst_if_rdata", if_rdata[0],     32'd0);
    check_eq("rst_mem_addr", mem_addr[0],     32'd0);
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h0050_0093;
    #1;
    check_eq("f_if_ready_T", 32'(if_ready[0]), 32'd1);
    check_eq("f_d_ready_T",  32'(d_ready[0]),  32'd0);
    step(); if_req = 1'b0;
    check_eq("f_ren_T1",  32'(mem_ren[0]), 32'd1);
    check_eq("f_wen_T1",  32'(mem_wen[0]), 32'd0);
    check_eq("f_addr_T1", mem_addr[0],     32'h0000_0040);
    check_eq("f_busy_T1", 32'(busy[0]),    32'd1);
    step();
    check_eq("f_ren_T2",   32'(mem_ren[0]),  32'd0);
    check_eq("f_valid_T2", 32'(if_valid[0]), 32'd0);
    step();
    check_eq("f_valid_T3", 32'(if_valid[0]), 32'd1);
    check_eq("f_rdata_T3", if_rdata[0],      32'h0050_0093);
    check_eq("f_dvalid_T3", 32'(d_valid[0]), 32'd0);
    step();
    check_eq("f_valid_T4", 32'(if_valid[0]), 32'd0);
    check_eq("f_busy_T4",  32'(busy[0]),     32'd0);

    // ---- 2: store, LATENCY = 2 (instance 0) ----
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_0100;
    d_wdata = 32'hDEAD_BEEF; d_mask = 4'b1111; mem_rdata = 32'h1234_5678;
    #1;
    check_eq("s_d_ready",  32'(d_ready[0]),  32'd1);
    check_eq("s_if_ready", 32'(if_ready[0]), 32'd0);
    step(); d_req = 1'b0; d_wen = 1'b0;
    check_eq("s_wen",   32'(mem_wen[0]), 32'd1);
    check_eq("s_ren",   32'(mem_ren[0]), 32'd0);
    check_eq("s_addr",  mem_addr[0],     32'h0000_0100);
    check_eq("s_wdata", mem_wdata[0],    32'hDEAD_BEEF);
    check_eq("s_mask",  32'(mem_mask[0]), 32'h0000_000F);
    step();
    check_eq("s_wen_off", 32'(mem_wen[0]), 32'd0);
    check_eq("s_hold_addr", mem_addr[0],   32'h0000_0100);
    step();
    check_eq("s_d_valid",  32'(d_valid[0]),  32'd1);
    check_eq("s_d_rdata",  d_rdata[0],       32'd0);
    check_eq("s_if_valid", 32'(if_valid[0]), 32'd0);
    check_eq("s_if_hold",  if_rdata[0],      32'h0050_0093);
    step();
    check_eq("s_d_valid_off", 32'(d_valid[0]), 32'd0);

    // ---- 5: reset during WAIT of a load (instance 0) ----
    d_req = 1'b1; d_addr = 32'h0000_0300; mem_rdata = 32'h7777_7777;
    #1;
    check_eq("r_d_ready", 32'(d_ready[0]), 32'd1);
    step(); d_req = 1'b0;
    step();
    check_eq("r_in_wait_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("r_busy",     32'(busy[0]),    32'd0);
    check_eq("r_ren",      32'(mem_ren[0]), 32'd0);
    check_eq("r_mem_addr", mem_addr[0],     32'd0);
    check_eq("r_if_rdata", if_rdata[0],     32'd0);
    check_eq("r_d_valid",  32'(d_valid[0]), 32'd0);
    step(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("r_no_valid_%0d", k), 32'(d_valid[0]), 32'd0);
      check_eq($sformatf("r_idle_%0d", k),     32'(busy[0]),    32'd0);
      step();
    end
    d_req = 1'b1; d_addr = 32'h0000_0304;
    #1;
    check_eq("r_reaccept", 32'(d_ready[0]), 32'd1);
    step(); d_req = 1'b0;
    check_eq("r_re_ren",  32'(mem_ren[0]), 32'd1);
    check_eq("r_re_addr", mem_addr[0],     32'h0000_0304);

    // ---- 3: starvation bound, both requests held (instance 0) ----
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0500;
    #1;
    for (int c = 0; c < 18; c++) begin
      check_eq($sformatf("arb_d_c%0d", c), 32'(d_ready[0]),
               32'((c % 3 == 0) && ((c / 3) % 3 != 2)));
      check_eq($sformatf("arb_i_c%0d", c), 32'(if_ready[0]),
               32'((c % 3 == 0) && ((c / 3) % 3 == 2)));
      step();
    end
    idle_inputs();

    // ---- 4: load then fetch back to back, LATENCY = 1 (instance 1) ----
    do_reset();
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0200;
    if_req = 1'b1; if_addr = 32'h0000_0044; mem_rdata = 32'hAAAA_0001;
    #1;
    check_eq("b_d_ready_T",  32'(d_ready[1]),  32'd1);
    check_eq("b_if_ready_T", 32'(if_ready[1]), 32'd0);
    step(); d_req = 1'b0;
    check_eq("b_ren_T1",     32'(mem_ren[1]),  32'd1);
    check_eq("b_addr_T1",    mem_addr[1],      32'h0000_0200);
    check_eq("b_if_rdy_T1",  32'(if_ready[1]), 32'd0);
    step();
    check_eq("b_d_valid_T2", 32'(d_valid[1]),  32'd1);
    check_eq("b_d_rdata_T2", d_rdata[1],       32'hAAAA_0001);
    check_eq("b_if_val_T2",  32'(if_valid[1]), 32'd0);
    check_eq("b_if_rdy_T2",  32'(if_ready[1]), 32'd1);
    mem_rdata = 32'hBBBB_0002;
    step(); if_req = 1'b0;
    check_eq("b_ren_T3",     32'(mem_ren[1]),  32'd1);
    check_eq("b_addr_T3",    mem_addr[1],      32'h0000_0044);
    check_eq("b_d_val_T3",   32'(d_valid[1]),  32'd0);
    step();
    check_eq("b_if_val_T4",  32'(if_valid[1]), 32'd1);
    check_eq("b_if_rd_T4",   if_rdata[1],      32'hBBBB_0002);
    check_eq("b_d_val_T4",   32'(d_valid[1]),  32'd0);
    check_eq("b_d_hold_T4",  d_rdata[1],       32'hAAAA_0001);
    step();
    check_eq("b_if_val_T5",  32'(if_valid[1]), 32'd0);
    check_eq("b_busy_T5",    32'(busy[1]),     32'd0);

    // ---- 6: LATENCY = 4 load (instance 2) ----
    do_reset();
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0400; mem_rdata = 32'h4444_0004;
    #1;
    check_eq("l4_busy_T",  32'(busy[2]),    32'd0);
    check_eq("l4_ready_T", 32'(d_ready[2]), 32'd1);
    step(); d_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check_eq($sformatf("l4_busy_T%0d", k),  32'(busy[2]),    32'd1);
      check_eq($sformatf("l4_ren_T%0d", k),   32'(mem_ren[2]), 32'(k == 1));
      check_eq($sformatf("l4_valid_T%0d", k), 32'(d_valid[2]), 32'(k == 5));
      step();
    end
    check_eq("l4_rdata",    d_rdata[2],      32'h4444_0004);
    check_eq("l4_busy_T6",  32'(busy[2]),    32'd0);
    check_eq("l4_valid_T6", 32'(d_valid[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
